uniter_rr_arbiter: RTL and testbench



---
 rtl/uniter_pkg.sv | 19 +
 rtl/uniter_rr_picker.sv | 50 +++++
 rtl/uniter_rr_arbiter.sv | 115 +++++++++++
 tb/tb_uniter_rr_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uniter_pkg.sv
// -----------------------------------------------------------------------------
// uniter_pkg
// Shared types for the valid/ready port uniter control path.
//   state_t : arbiter FSM state (IDLE = no grant held, BUSY = grant held)
//   sel_t   : select index at the default port-count width
// -----------------------------------------------------------------------------
package uniter_pkg;

   // Default select width (log2 of the number of master ports).
   localparam int PORTS_N_DEFAULT = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef logic [PORTS_N_DEFAULT-1:0] sel_t;

endpackage : uniter_pkg

// File: rtl/uniter_rr_picker.sv
// -----------------------------------------------------------------------------
// uniter_rr_picker
// Combinational round-robin picker. Searches the request vector starting one
// position after last_grant, wrapping modulo PORTS_W, and ending at last_grant
// itself. Implemented as a double-width rotate followed by a priority encoder.
//
// Ports:
//   req        in   PORTS_W  request vector
//   last_grant in   PORTS_N  index of the most recent grant
//   found      out  1        at least one request bit is set
//   winner     out  PORTS_N  chosen index (meaningful only when found=1)
// -----------------------------------------------------------------------------
module uniter_rr_picker #(
   parameter int PORTS_N = 4,
   parameter int PORTS_W = 1 << PORTS_N
) (
   input  logic [PORTS_W-1:0] req,
   input  logic [PORTS_N-1:0] last_grant,
   output logic               found,
   output logic [PORTS_N-1:0] winner
);

   logic [PORTS_N:0]     shift_amt;
   logic [2*PORTS_W-1:0] req_dbl;
   logic [PORTS_W-1:0]   req_rot;
   logic [PORTS_N-1:0]   offset;

   // Rotating right by last_grant+1 puts the highest-priority port at bit 0.
   // shift_amt can reach PORTS_W, so it carries one extra bit; the doubled
   // vector keeps the part-select in range for every shift.
   assign shift_amt = {1'b0, last_grant} + (PORTS_N+1)'(1);
   assign req_dbl   = {req, req};
   assign req_rot   = req_dbl[shift_amt +: PORTS_W];

   // Lowest set bit of the rotated vector wins; scanning downward lets the
   // last assignment be the lowest index.
   always_comb begin
      offset = '0;
      for (int i = PORTS_W - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            offset = PORTS_N'(i);
         end
      end
   end

   assign found  = |req;
   // Undo the rotation; the PORTS_N-bit sum wraps naturally modulo PORTS_W.
   assign winner = last_grant + PORTS_N'(1) + offset;

endmodule : uniter_rr_picker

// File: rtl/uniter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// uniter_rr_arbiter
// Packet-locked round-robin arbiter that drives the uniter's select input.
// A grant is taken from IDLE one cycle after any request appears, held for the
// whole packet, and handed over on the cycle the last beat handshakes. On
// handover the released port is masked so another requester wins if present;
// otherwise the arbiter returns to IDLE with o_sel frozen.
//
// Ports:
//   i_clk          in   1        clock
//   i_reset        in   1        synchronous active-high reset
//   i_master_valid in   PORTS_W  per-port beat valid
//   i_master_last  in   PORTS_W  per-port last-beat flag (qualified by valid)
//   i_slave_ready  in   1        downstream ready
//   o_sel          out  PORTS_N  registered selected port index
//   o_sel_valid    out  1        a grant is held
//   o_grant        out  PORTS_W  one-hot of o_sel, zero when no grant held
// -----------------------------------------------------------------------------
module uniter_rr_arbiter
   import uniter_pkg::*;
#(
   parameter int PORTS_N = PORTS_N_DEFAULT,
   parameter int PORTS_W = 1 << PORTS_N
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [PORTS_W-1:0] i_master_valid,
   input  logic [PORTS_W-1:0] i_master_last,
   input  logic               i_slave_ready,
   output logic [PORTS_N-1:0] o_sel,
   output logic               o_sel_valid,
   output logic [PORTS_W-1:0] o_grant
);

   state_t             state_reg, state_next;
   logic [PORTS_N-1:0] sel_reg, sel_next;
   logic [PORTS_N-1:0] last_grant_reg, last_grant_next;

   logic [PORTS_W-1:0] sel_onehot;
   logic [PORTS_W-1:0] req_vec;
   logic               pick_found;
   logic [PORTS_N-1:0] pick_winner;
   logic               fire;
   logic               release_beat;

   assign sel_onehot   = PORTS_W'(1) << sel_reg;
   assign fire         = i_master_valid[sel_reg] & i_slave_ready;
   assign release_beat = fire & i_master_last[sel_reg];

   // A single picker serves both paths: from IDLE every requester competes;
   // while BUSY only the release decision consults it, with the releasing
   // port removed so it cannot immediately re-win.
   assign req_vec = (state_reg == IDLE) ? i_master_valid
                                        : (i_master_valid & ~sel_onehot);

   uniter_rr_picker #(
      .PORTS_N (PORTS_N),
      .PORTS_W (PORTS_W)
   ) u_picker (
      .req        (req_vec),
      .last_grant (last_grant_reg),
      .found      (pick_found),
      .winner     (pick_winner)
   );

   always_comb begin
      state_next      = state_reg;
      sel_next        = sel_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               state_next      = BUSY;
               sel_next        = pick_winner;
               last_grant_next = pick_winner;
            end
         end
         BUSY: begin
            if (release_beat) begin
               if (pick_found) begin
                  sel_next        = pick_winner;
                  last_grant_next = pick_winner;
               end else begin
                  // No other requester: drop the grant but keep o_sel.
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg      <= IDLE;
         sel_reg        <= '0;
         // Pointing at the top port makes port 0 the first in line.
         last_grant_reg <= PORTS_N'(PORTS_W - 1);
      end else begin
         state_reg      <= state_next;
         sel_reg        <= sel_next;
         last_grant_reg <= last_grant_next;
      end
   end

   assign o_sel       = sel_reg;
   assign o_sel_valid = (state_reg == BUSY);

   for (genvar gi = 0; gi < PORTS_W; gi++) begin : g_grant
      assign o_grant[gi] = o_sel_valid && (sel_reg == PORTS_N'(gi));
   end

endmodule : uniter_rr_arbiter

// File: tb/tb_uniter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uniter_rr_arbiter
// Self-checking bench for uniter_rr_arbiter at PORTS_N=2 / PORTS_W=4.
// Each cycle's expected {o_sel_valid, o_sel, o_grant} is pushed to a queue
// when the stimulus is applied, then popped and compared one clock later.
// -----------------------------------------------------------------------------
module tb_uniter_rr_arbiter;

   localparam int PN = 2;
   localparam int PW = 4;

   logic          clk;
   logic          i_reset;
   logic [PW-1:0] i_master_valid;
   logic [PW-1:0] i_master_last;
   logic          i_slave_ready;
   logic [PN-1:0] o_sel;
   logic          o_sel_valid;
   logic [PW-1:0] o_grant;

   int checks = 0;
   int errors = 0;

   // Expected {sel_valid, sel[1:0], grant[3:0]}
   logic [6:0] sb_q [$];

   uniter_rr_arbiter #(
      .PORTS_N (PN),
      .PORTS_W (PW)
   ) dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_master_valid (i_master_valid),
      .i_master_last  (i_master_last),
      .i_slave_ready  (i_slave_ready),
      .o_sel          (o_sel),
      .o_sel_valid    (o_sel_valid),
      .o_grant        (o_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Applies one cycle of stimulus, records its expected outcome, and
   // advances to 1 ns past the next rising edge.
   task automatic drive_cycle(input logic rst, input logic [3:0] v,
                              input logic [3:0] l, input logic r,
                              input logic [6:0] exp_out);
      sb_q.push_back(exp_out);
      i_reset        = rst;
      i_master_valid = v;
      i_master_last  = l;
      i_slave_ready  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] obs, exp_out;
      for (int c = 0; c < 7; c++) begin
         drive_cycle((c < 2) ? 1'b1 : 1'b0, 4'b0000, 4'b0000, 1'b1, 7'b0_00_0000);
         obs = {o_sel_valid, o_sel, o_grant};
         exp_out = sb_q.pop_front();
         checks++;
         if (obs !== exp_out) begin
            errors++;
            $display("FAIL reset[%0d] got v=%b sel=%0d grant=%b want v=%b sel=%0d grant=%b",
                     c, obs[6], obs[5:4], obs[3:0], exp_out[6], exp_out[5:4], exp_out[3:0]);
         end else begin
            $display("reset[%0d] v=%b sel=%0d grant=%b ok", c, obs[6], obs[5:4], obs[3:0]);
         end
      end
   endtask

   task automatic test_handover();
      logic [3:0] v  [6] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1000, 4'b0000};
      logic [3:0] l  [6] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1000, 4'b0000};
      logic [6:0] ex [6] = '{7'b0_00_0000, 7'b1_01_0010, 7'b1_11_1000,
                             7'b1_11_1000, 7'b0_11_0000, 7'b0_11_0000};
      logic [6:0] obs, exp_out;
      for (int c = 0; c < 6; c++) begin
         drive_cycle(c == 0, v[c], l[c], 1'b1, ex[c]);
         obs = {o_sel_valid, o_sel, o_grant};
         exp_out = sb_q.pop_front();
         checks++;
         if (obs !== exp_out) begin
            errors++;
            $display("FAIL handover[%0d] got v=%b sel=%0d grant=%b want v=%b sel=%0d grant=%b",
                     c, obs[6], obs[5:4], obs[3:0], exp_out[6], exp_out[5:4], exp_out[3:0]);
         end else begin
            $display("handover[%0d] v=%b sel=%0d grant=%b ok", c, obs[6], obs[5:4], obs[3:0]);
         end
      end
   endtask

   task automatic test_packet_lock();
      // Port 2 sends 3 beats under a toggling ready while ports 0 and 3 wait
      // with last asserted (ignored: they are not granted).
      logic [3:0] v  [9] = '{4'b0000, 4'b0100, 4'b1101, 4'b1101, 4'b1101,
                             4'b1101, 4'b1101, 4'b1001, 4'b0001};
      logic [3:0] l  [9] = '{4'b0000, 4'b0000, 4'b1001, 4'b1001, 4'b1001,
                             4'b1001, 4'b1101, 4'b1001, 4'b0001};
      logic       r  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [6:0] ex [9] = '{7'b0_00_0000, 7'b1_10_0100, 7'b1_10_0100,
                             7'b1_10_0100, 7'b1_10_0100, 7'b1_10_0100,
                             7'b1_11_1000, 7'b1_00_0001, 7'b0_00_0000};
      logic [6:0] obs, exp_out;
      for (int c = 0; c < 9; c++) begin
         drive_cycle(c == 0, v[c], l[c], r[c], ex[c]);
         obs = {o_sel_valid, o_sel, o_grant};
         exp_out = sb_q.pop_front();
         checks++;
         if (obs !== exp_out) begin
            errors++;
            $display("FAIL packet_lock[%0d] got v=%b sel=%0d grant=%b want v=%b sel=%0d grant=%b",
                     c, obs[6], obs[5:4], obs[3:0], exp_out[6], exp_out[5:4], exp_out[3:0]);
         end else begin
            $display("packet_lock[%0d] v=%b sel=%0d grant=%b ok", c, obs[6], obs[5:4], obs[3:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      // All ports send single-beat packets continuously: strict rotation.
      logic [1:0] order [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      logic [6:0] obs, exp_out;
      drive_cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 7'b0_00_0000);
      obs = {o_sel_valid, o_sel, o_grant};
      exp_out = sb_q.pop_front();
      checks++;
      if (obs !== exp_out) begin
         errors++;
         $display("FAIL back_to_back[rst] got %b want %b", obs, exp_out);
      end
      for (int c = 0; c < 9; c++) begin
         if (c < 8) begin
            exp_out = {1'b1, order[c], 4'b0001 << order[c]};
            drive_cycle(1'b0, 4'b1111, 4'b1111, 1'b1, exp_out);
         end else begin
            // Valids drop after the last grant: the grant on port 3 is held.
            drive_cycle(1'b0, 4'b0000, 4'b0000, 1'b1, 7'b1_11_1000);
         end
         obs = {o_sel_valid, o_sel, o_grant};
         exp_out = sb_q.pop_front();
         checks++;
         if (obs !== exp_out) begin
            errors++;
            $display("FAIL back_to_back[%0d] got v=%b sel=%0d grant=%b want v=%b sel=%0d grant=%b",
                     c, obs[6], obs[5:4], obs[3:0], exp_out[6], exp_out[5:4], exp_out[3:0]);
         end else begin
            $display("back_to_back[%0d] v=%b sel=%0d grant=%b ok", c, obs[6], obs[5:4], obs[3:0]);
         end
      end
   endtask

   task automatic test_bubble();
      // Granted port 1 drops valid for 3 cycles while port 0 waits with last.
      logic [3:0] v  [7] = '{4'b0000, 4'b0010, 4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b0011};
      logic [3:0] l  [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
      logic [6:0] ex [7] = '{7'b0_00_0000, 7'b1_01_0010, 7'b1_01_0010, 7'b1_01_0010,
                             7'b1_01_0010, 7'b1_01_0010, 7'b1_00_0001};
      logic [6:0] obs, exp_out;
      for (int c = 0; c < 7; c++) begin
         drive_cycle(c == 0, v[c], l[c], 1'b1, ex[c]);
         obs = {o_sel_valid, o_sel, o_grant};
         exp_out = sb_q.pop_front();
         checks++;
         if (obs !== exp_out) begin
            errors++;
            $display("FAIL bubble[%0d] got v=%b sel=%0d grant=%b want v=%b sel=%0d grant=%b",
                     c, obs[6], obs[5:4], obs[3:0], exp_out[6], exp_out[5:4], exp_out[3:0]);
         end else begin
            $display("bubble[%0d] v=%b sel=%0d grant=%b ok", c, obs[6], obs[5:4], obs[3:0]);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      logic       rs [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] l  [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
      logic [3:0] v  [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
      logic [6:0] ex [6] = '{7'b0_00_0000, 7'b1_10_0100, 7'b1_10_0100,
                             7'b0_00_0000, 7'b1_10_0100, 7'b1_10_0100};
      logic [6:0] obs, exp_out;
      for (int c = 0; c < 6; c++) begin
         drive_cycle(rs[c], v[c], l[c], 1'b1, ex[c]);
         obs = {o_sel_valid, o_sel, o_grant};
         exp_out = sb_q.pop_front();
         checks++;
         if (obs !== exp_out) begin
            errors++;
            $display("FAIL reset_mid[%0d] got v=%b sel=%0d grant=%b want v=%b sel=%0d grant=%b",
                     c, obs[6], obs[5:4], obs[3:0], exp_out[6], exp_out[5:4], exp_out[3:0]);
         end else begin
            $display("reset_mid[%0d] v=%b sel=%0d grant=%b ok", c, obs[6], obs[5:4], obs[3:0]);
         end
      end
   endtask

   initial begin
      i_reset        = 1'b1;
      i_master_valid = '0;
      i_master_last  = '0;
      i_slave_ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_handover();
      test_packet_lock();
      test_back_to_back();
      test_bubble();
      test_reset_mid_packet();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_uniter_rr_arbiter
